// File: rtl/morse_digit_sequencer_if.sv
// Host and encoder side signals of the Morse digit sequencer.
// slave: the sequencer itself; master: whatever drives the host pushes and models the encoder.
interface morse_digit_sequencer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [3:0]    push_data;
  logic          full;
  logic [CW-1:0] count;
  logic          enc_start;
  logic [3:0]    enc_digit;
  logic          enc_busy;
  logic          busy;
  logic          msg_done;
  logic          err;
  logic          clr_err;

  modport slave (
    input  push, push_data, enc_busy, clr_err,
    output full, count, enc_start, enc_digit, busy, msg_done, err
  );

  modport master (
    output push, push_data, enc_busy, clr_err,
    input  full, count, enc_start, enc_digit, busy, msg_done, err
  );
endinterface

// File: rtl/morse_digit_sequencer.sv
// Message-level sequencer for the single-digit Morse encoder: queues BCD digits and
// word spaces, dispatches digits one at a time and times inter-character/word gaps.
module morse_digit_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  morse_digit_sequencer_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned GAP_CHAR = 3 * UNIT_CYCLES;
  localparam int unsigned GAP_WORD = 4 * UNIT_CYCLES;
  localparam int unsigned GW       = $clog2(GAP_WORD + 1);
  localparam int unsigned TW       = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam logic [3:0] CODE_SPACE = 4'd15;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_in_q;

  logic          enc_start_q, enc_start_d;
  logic [3:0]    enc_digit_q, enc_digit_d;
  logic          msg_done_q, msg_done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic [3:0]    head;
  logic          data_ok, push_ok, push_err, empty, pop, timeout_err;

  assign head     = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign data_ok  = (bus.push_data <= 4'd9) || (bus.push_data == CODE_SPACE);
  assign push_ok  = bus.push && !full_q && data_ok;
  assign push_err = bus.push && (full_q || !data_ok);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    timeout_err = 1'b0;
    enc_start_d = 1'b0;
    enc_digit_d = enc_digit_q;
    msg_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_START: begin
        enc_start_d = 1'b1;
        timer_d     = '0;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (busy_in_q) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          gap_d       = GW'(GAP_CHAR);
          state_d     = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy_in_q) begin
          gap_d   = GW'(GAP_CHAR);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // <= 1 rather than == 1 so a zero count can never wrap
        if (gap_q <= GW'(1)) begin
          state_d = S_IDLE;
          if (!empty) pop = 1'b1;
          else        msg_done_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A popped item either starts the encoder or opens a word-space gap
    if (pop) begin
      enc_digit_d = head;
      if (head == CODE_SPACE) begin
        gap_d   = GW'(GAP_WORD);
        state_d = S_GAP;
      end else begin
        state_d = S_START;
      end
    end

    count_d = count_q + CW'(push_ok) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
    err_d   = (err_q && !bus.clr_err) || push_err || timeout_err;
  end

  // FSM, timers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      timer_q     <= '0;
      busy_in_q   <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      enc_start_q <= 1'b0;
      enc_digit_q <= '0;
      msg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      busy_in_q   <= bus.enc_busy;
      count_q     <= count_d;
      full_q      <= full_d;
      enc_start_q <= enc_start_d;
      enc_digit_q <= enc_digit_d;
      msg_done_q  <= msg_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // FIFO pointers; reset empties the queue without clearing storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.push_data;
  end

  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.enc_start = enc_start_q;
  assign bus.enc_digit = enc_digit_q;
  assign bus.busy      = busy_q;
  assign bus.msg_done  = msg_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_morse_digit_sequencer.sv
// Directed bench for morse_digit_sequencer with UNIT_CYCLES=4, DEPTH=8, ACK_TIMEOUT=16.
module tb_morse_digit_sequencer;

  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  // encoder model: 0 = normal (1-cycle delay, 10 busy cycles), 1 = dead, 2 = held busy
  int   enc_mode;
  int   bcnt;
  bit   pend;
  int   last_fall;

  morse_digit_sequencer_if #(.DEPTH(DEPTH)) bus ();

  morse_digit_sequencer #(
    .DEPTH      (DEPTH),
    .UNIT_CYCLES(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Hard stop in case the run wanders off
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Encoder model, updated at negedges
  initial begin
    bus.enc_busy = 1'b0;
    bcnt = 0;
    pend = 1'b0;
    last_fall = 0;
    forever begin
      @(negedge clk);
      if (enc_mode == 2) begin
        bus.enc_busy = 1'b1;
        pend = 1'b0;
        bcnt = 0;
      end else if (enc_mode == 1) begin
        if (bus.enc_busy) begin
          bus.enc_busy = 1'b0;
          last_fall = cyc + 1;
        end
        pend = 1'b0;
        bcnt = 0;
      end else begin
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) begin
            bus.enc_busy = 1'b0;
            last_fall = cyc + 1;
          end
        end else if (pend) begin
          bus.enc_busy = 1'b1;
          bcnt = 10;
          pend = 1'b0;
        end else if (bus.enc_busy) begin
          bus.enc_busy = 1'b0;
          last_fall = cyc + 1;
        end
        if (bus.enc_start) pend = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Caller is at a negedge; the push is sampled at the next posedge.
  task automatic do_push(input logic [3:0] d);
    bus.push      = 1'b1;
    bus.push_data = d;
    @(negedge clk);
    bus.push      = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.enc_start) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.msg_done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bit found;
    int s0;
    int nst;
    int first_d;
    int last_d;

    checks = 0;
    failures = 0;
    enc_mode = 0;
    bus.push = 1'b0;
    bus.push_data = 4'd0;
    bus.clr_err = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_enc_start", 32'(bus.enc_start), 0);
    chk("rst_enc_digit", 32'(bus.enc_digit), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_msg_done", 32'(bus.msg_done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Push 3 then 7: latency, digit-to-digit spacing, msg_done
    do_push(4'd3);
    chk("a_busy_edge_k", 32'(bus.busy), 1);
    chk("a_count_k", 32'(bus.count), 1);
    do_push(4'd7);
    chk("a_count_push_pop", 32'(bus.count), 1);
    chk("a_start_k1", 32'(bus.enc_start), 0);
    @(negedge clk);
    chk("a_start_k2", 32'(bus.enc_start), 1);
    chk("a_digit_3", 32'(bus.enc_digit), 3);
    @(negedge clk);
    chk("a_start_k3", 32'(bus.enc_start), 0);
    wait_start(100, found);
    chk("a_second_start_seen", 32'(found), 1);
    chk("a_digit_7", 32'(bus.enc_digit), 7);
    chk("a_fall_to_start", 32'(cyc - last_fall), 14);
    wait_done(100, found);
    chk("a_msg_done_seen", 32'(found), 1);
    chk("a_busy_with_done", 32'(bus.busy), 0);
    chk("a_err", 32'(bus.err), 0);
    @(negedge clk);
    chk("a_msg_done_one_cycle", 32'(bus.msg_done), 0);
    repeat (3) @(negedge clk);

    // Push 5, space, 2: 3+4 units of silence, no start for the space
    do_push(4'd5);
    do_push(4'd15);
    do_push(4'd2);
    chk("b_start_5", 32'(bus.enc_start), 1);
    chk("b_digit_5", 32'(bus.enc_digit), 5);
    wait_start(200, found);
    chk("b_next_start_seen", 32'(found), 1);
    chk("b_digit_2", 32'(bus.enc_digit), 2);
    chk("b_fall_to_start", 32'(cyc - last_fall), 30);
    wait_done(100, found);
    chk("b_msg_done_seen", 32'(found), 1);
    chk("b_err", 32'(bus.err), 0);
    repeat (3) @(negedge clk);

    // Fill the FIFO while the encoder is held busy, overflow, clear
    enc_mode = 2;
    do_push(4'd1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) do_push(4'(i));
    chk("c_count_full", 32'(bus.count), 8);
    chk("c_full", 32'(bus.full), 1);
    chk("c_err_before", 32'(bus.err), 0);
    do_push(4'd9);
    chk("c_count_after_drop", 32'(bus.count), 8);
    chk("c_err_overflow", 32'(bus.err), 1);
    pulse_clr();
    chk("c_err_cleared", 32'(bus.err), 0);
    bus.clr_err = 1'b1;
    do_push(4'd4);
    bus.clr_err = 1'b0;
    chk("c_err_new_wins", 32'(bus.err), 1);
    chk("c_count_still_8", 32'(bus.count), 8);
    pulse_clr();
    chk("c_err_cleared2", 32'(bus.err), 0);
    enc_mode = 0;
    nst = 0;
    first_d = -1;
    last_d = -1;
    found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.enc_start) begin
        if (nst == 0) first_d = int'(bus.enc_digit);
        last_d = int'(bus.enc_digit);
        nst++;
      end
      if (bus.msg_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("c_drain_done", 32'(found), 1);
    chk("c_drain_starts", 32'(nst), 8);
    chk("c_first_digit", 32'(first_d), 0);
    chk("c_last_digit", 32'(last_d), 7);
    chk("c_err_after_drain", 32'(bus.err), 0);
    repeat (3) @(negedge clk);

    // Invalid code 12
    do_push(4'd12);
    chk("d_count", 32'(bus.count), 0);
    chk("d_err", 32'(bus.err), 1);
    chk("d_busy", 32'(bus.busy), 0);
    nst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.enc_start) nst++;
    end
    chk("d_no_start", 32'(nst), 0);
    pulse_clr();
    chk("d_err_cleared", 32'(bus.err), 0);

    // Dead encoder: timeout after 16 cycles, then 3-unit gap, next digit
    enc_mode = 1;
    do_push(4'd4);
    do_push(4'd6);
    wait_start(10, found);
    chk("e_start_seen", 32'(found), 1);
    chk("e_digit_4", 32'(bus.enc_digit), 4);
    s0 = cyc;
    repeat (15) @(negedge clk);
    chk("e_err_at_15", 32'(bus.err), 0);
    @(negedge clk);
    chk("e_err_at_16", 32'(bus.err), 1);
    wait_start(50, found);
    chk("e_next_start_seen", 32'(found), 1);
    chk("e_digit_6", 32'(bus.enc_digit), 6);
    chk("e_start_to_start", 32'(cyc - s0), 29);
    wait_done(100, found);
    chk("e_msg_done_seen", 32'(found), 1);
    pulse_clr();
    enc_mode = 0;
    repeat (3) @(negedge clk);

    // Reset in WAIT_DONE with three items queued
    enc_mode = 2;
    do_push(4'd2);
    repeat (6) @(negedge clk);
    do_push(4'd1);
    do_push(4'd2);
    do_push(4'd3);
    chk("f_count_3", 32'(bus.count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_count", 32'(bus.count), 0);
    chk("f_rst_busy", 32'(bus.busy), 0);
    chk("f_rst_digit", 32'(bus.enc_digit), 0);
    chk("f_rst_start", 32'(bus.enc_start), 0);
    chk("f_rst_full", 32'(bus.full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enc_mode = 0;
    nst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.enc_start) nst++;
    end
    chk("f_no_start_after_rst", 32'(nst), 0);
    chk("f_idle_busy", 32'(bus.busy), 0);
    do_push(4'd8);
    wait_start(10, found);
    chk("f_new_start_seen", 32'(found), 1);
    chk("f_digit_8", 32'(bus.enc_digit), 8);
    wait_done(100, found);
    chk("f_msg_done_seen", 32'(found), 1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
